// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator front end.
package calc_pkg;

   typedef enum logic [2:0] {
      ST_ENTER_A,
      ST_ENTER_B,
      ST_WR1,
      ST_WR2,
      ST_WR3,
      ST_RUN,
      ST_CONV,
      ST_SHOW
   } calc_state_t;

   localparam logic [3:0] OP_ADD     = 4'hA;
   localparam logic [3:0] OP_SUB     = 4'hB;
   localparam logic [3:0] OP_MUL     = 4'hC;
   localparam logic [3:0] OP_DIV     = 4'hD;
   localparam logic [3:0] KEY_ENTER  = 4'hE;
   localparam logic [3:0] KEY_RECALL = 4'hF;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_X     = 8'h78;
   localparam logic [7:0] CH_SLASH = 8'h2F;

   localparam logic [127:0] ROW_BLANK = {16{CH_SPACE}};
   localparam logic [127:0] ROW2_DIV0 = {"=DIV0", {11{CH_SPACE}}};
   localparam logic [127:0] ROW2_OVF  = {"=OVF", {12{CH_SPACE}}};
   localparam logic [127:0] ROW2_TIME = {"=TIME", {11{CH_SPACE}}};

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   function automatic logic [7:0] op_char(input logic [3:0] op);
      case (op)
         OP_ADD:  return CH_PLUS;
         OP_SUB:  return CH_MINUS;
         OP_MUL:  return CH_X;
         OP_DIV:  return CH_SLASH;
         default: return CH_SPACE;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 10 BCD nibbles, done exactly 33 cycles after start.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        done,
   output logic [39:0] bcd
);

   logic [31:0] shift_r;
   logic [4:0]  cnt_r;
   logic        run_r;
   logic [39:0] adj_s;

   // Add-3 correction of every nibble ahead of the next shift
   always_comb begin
      adj_s = 40'd0;
      for (int i = 0; i < 10; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = bcd[4*i +: 4];
         end
      end
   end

   // Load on start, then 32 shift steps; done pulses with the final step
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         shift_r <= 32'd0;
         cnt_r   <= 5'd0;
         run_r   <= 1'b0;
         done    <= 1'b0;
         bcd     <= 40'd0;
      end else begin
         done <= 1'b0;
         if (start) begin
            shift_r <= bin;
            bcd     <= 40'd0;
            cnt_r   <= 5'd0;
            run_r   <= 1'b1;
         end else if (run_r) begin
            {bcd, shift_r} <= {adj_s[38:0], shift_r, 1'b0};
            cnt_r          <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
               run_r <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/calc_io_ctrl.sv
// Keypad-to-CPU calculator front end: operand entry, CPU memory writes, result display.
// Optional CPU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_io_ctrl
   import calc_pkg::*;
#(
   parameter int          DIGITS         = 4,
   parameter int          RES_DIGITS     = 8,
   parameter logic [31:0] ADDR_OP1       = 32'd220,
   parameter logic [31:0] ADDR_OP2       = 32'd240,
   parameter logic [31:0] ADDR_OPC       = 32'd260,
   parameter logic [31:0] ADDR_IDLE      = 32'd320,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   input  logic         cpu_done,
   input  logic [31:0]  res_data,
   output logic [31:0]  bus_addr,
   output logic [31:0]  bus_wdata,
   output logic         bus_we,
   output logic         cpu_en,
   output logic         busy,
   output logic [127:0] row1,
   output logic [127:0] row2
);

   localparam int          BCD_W     = 4 * DIGITS;
   localparam logic [3:0]  DIGITS_W  = 4'(DIGITS);
   localparam logic [63:0] ANS_LIMIT = pow10(DIGITS);
`ifdef CALC_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

   function automatic logic [127:0] render_row1(input logic [BCD_W-1:0] a,
                                               input logic [3:0] op,
                                               input logic [BCD_W-1:0] b);
      logic [127:0] r;
      r = ROW_BLANK;
      for (int i = 0; i < DIGITS; i++) begin
         r[127-8*i -: 8]            = CH_ZERO | {4'd0, a[4*(DIGITS-1-i) +: 4]};
         r[127-8*(DIGITS+1+i) -: 8] = CH_ZERO | {4'd0, b[4*(DIGITS-1-i) +: 4]};
      end
      r[127-8*DIGITS -: 8] = op_char(op);
      return r;
   endfunction

   function automatic logic [127:0] render_row2(input logic [39:0] bcd, input logic neg);
      logic [127:0] r;
      r = ROW_BLANK;
      r[127:120] = CH_EQ;
      r[119:112] = neg ? CH_MINUS : CH_SPACE;
      for (int i = 0; i < RES_DIGITS; i++) begin
         r[127-8*(2+i) -: 8] = CH_ZERO | {4'd0, bcd[4*(RES_DIGITS-1-i) +: 4]};
      end
      return r;
   endfunction

   calc_state_t      state_r;
   logic [31:0]      a_bin_r, b_bin_r, res_r, ans_r;
   logic [BCD_W-1:0] a_bcd_r, b_bcd_r, ans_bcd_r;
   logic [3:0]       a_cnt_r, b_cnt_r, op_r;
   logic             ans_valid_r, conv_start_r;
`ifdef CALC_TIMEOUT_EN
   logic [31:0]      timer_r;
`endif

   logic             is_digit_s, is_op_s, recall_ok_s, conv_done_s, ovf_s;
   logic [31:0]      a_bin_app_s, b_bin_app_s, mag_s;
   logic [BCD_W-1:0] a_bcd_app_s, b_bcd_app_s;
   logic [39:0]      conv_bcd_s;

   // Key decode, digit-appended operands, recall eligibility and result magnitude
   always_comb begin
      is_digit_s  = (key_code <= 4'd9);
      is_op_s     = (key_code >= OP_ADD) && (key_code <= OP_DIV);
      a_bin_app_s = a_bin_r * 32'd10 + {28'd0, key_code};
      b_bin_app_s = b_bin_r * 32'd10 + {28'd0, key_code};
      a_bcd_app_s = BCD_W'({a_bcd_r, key_code});
      b_bcd_app_s = BCD_W'({b_bcd_r, key_code});
      recall_ok_s = ans_valid_r && !ans_r[31] && ({32'd0, ans_r} < ANS_LIMIT);
      if (res_r[31]) begin
         mag_s = ~res_r + 32'd1;
      end else begin
         mag_s = res_r;
      end
      ovf_s = ((conv_bcd_s >> (4 * RES_DIGITS)) != 40'd0);
   end

   bin2bcd_seq u_conv (
      .clk   (clk),
      .nrst  (nrst),
      .start (conv_start_r),
      .bin   (mag_s),
      .done  (conv_done_s),
      .bcd   (conv_bcd_s)
   );

   // Main controller FSM with registered bus, CPU and display outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r      <= ST_ENTER_A;
         a_bin_r      <= 32'd0;
         b_bin_r      <= 32'd0;
         a_bcd_r      <= '0;
         b_bcd_r      <= '0;
         a_cnt_r      <= 4'd0;
         b_cnt_r      <= 4'd0;
         op_r         <= OP_ADD;
         res_r        <= 32'd0;
         ans_r        <= 32'd0;
         ans_bcd_r    <= '0;
         ans_valid_r  <= 1'b0;
         conv_start_r <= 1'b0;
         bus_addr     <= ADDR_IDLE;
         bus_wdata    <= 32'd0;
         bus_we       <= 1'b0;
         cpu_en       <= 1'b0;
         busy         <= 1'b0;
         row1         <= ROW_BLANK;
         row2         <= ROW_BLANK;
`ifdef CALC_TIMEOUT_EN
         timer_r      <= 32'd0;
`endif
      end else begin
         conv_start_r <= 1'b0;
         case (state_r)
            ST_ENTER_A: begin
               if (key_valid) begin
                  if (is_digit_s) begin
                     if (a_cnt_r < DIGITS_W) begin
                        a_bin_r <= a_bin_app_s;
                        a_bcd_r <= a_bcd_app_s;
                        a_cnt_r <= a_cnt_r + 4'd1;
                        row1    <= render_row1(a_bcd_app_s, op_r, b_bcd_r);
                     end
                  end else if (is_op_s) begin
                     op_r    <= key_code;
                     state_r <= ST_ENTER_B;
                     row1    <= render_row1(a_bcd_r, key_code, b_bcd_r);
                  end else if (key_code == KEY_RECALL && recall_ok_s) begin
                     a_bin_r <= ans_r;
                     a_bcd_r <= ans_bcd_r;
                     a_cnt_r <= DIGITS_W;
                     row1    <= render_row1(ans_bcd_r, op_r, b_bcd_r);
                  end
               end
            end
            ST_ENTER_B: begin
               if (key_valid) begin
                  if (is_digit_s) begin
                     if (b_cnt_r < DIGITS_W) begin
                        b_bin_r <= b_bin_app_s;
                        b_bcd_r <= b_bcd_app_s;
                        b_cnt_r <= b_cnt_r + 4'd1;
                        row1    <= render_row1(a_bcd_r, op_r, b_bcd_app_s);
                     end
                  end else if (is_op_s) begin
                     op_r <= key_code;
                     row1 <= render_row1(a_bcd_r, key_code, b_bcd_r);
                  end else if (key_code == KEY_RECALL) begin
                     if (recall_ok_s) begin
                        b_bin_r <= ans_r;
                        b_bcd_r <= ans_bcd_r;
                        b_cnt_r <= DIGITS_W;
                        row1    <= render_row1(a_bcd_r, op_r, ans_bcd_r);
                     end
                  end else if (op_r == OP_DIV && b_bin_r == 32'd0) begin
                     state_r <= ST_SHOW;
                     busy    <= 1'b1;
                     row2    <= ROW2_DIV0;
                  end else begin
                     state_r   <= ST_WR1;
                     busy      <= 1'b1;
                     bus_addr  <= ADDR_OP1;
                     bus_wdata <= a_bin_r;
                     bus_we    <= 1'b1;
                  end
               end
            end
            // Each write state presents its own word; the next one is set up here
            ST_WR1: begin
               state_r   <= ST_WR2;
               bus_addr  <= ADDR_OP2;
               bus_wdata <= b_bin_r;
            end
            ST_WR2: begin
               state_r   <= ST_WR3;
               bus_addr  <= ADDR_OPC;
               bus_wdata <= {28'd0, op_r};
            end
            ST_WR3: begin
               state_r   <= ST_RUN;
               bus_addr  <= ADDR_IDLE;
               bus_wdata <= 32'd0;
               bus_we    <= 1'b0;
               cpu_en    <= 1'b1;
`ifdef CALC_TIMEOUT_EN
               timer_r   <= 32'd0;
`endif
            end
            ST_RUN: begin
               if (cpu_done) begin
                  res_r        <= res_data;
                  cpu_en       <= 1'b0;
                  conv_start_r <= 1'b1;
                  state_r      <= ST_CONV;
               end
`ifdef CALC_TIMEOUT_EN
               else if (timer_r == TIMEOUT_LAST) begin
                  cpu_en  <= 1'b0;
                  row2    <= ROW2_TIME;
                  state_r <= ST_SHOW;
               end else begin
                  timer_r <= timer_r + 32'd1;
               end
`endif
            end
            ST_CONV: begin
               if (conv_done_s) begin
                  row2        <= ovf_s ? ROW2_OVF : render_row2(conv_bcd_s, res_r[31]);
                  ans_r       <= res_r;
                  ans_bcd_r   <= conv_bcd_s[BCD_W-1:0];
                  ans_valid_r <= 1'b1;
                  state_r     <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (key_valid && key_code == KEY_ENTER) begin
                  state_r <= ST_ENTER_A;
                  busy    <= 1'b0;
                  row1    <= ROW_BLANK;
                  row2    <= ROW_BLANK;
                  a_bin_r <= 32'd0;
                  b_bin_r <= 32'd0;
                  a_bcd_r <= '0;
                  b_bcd_r <= '0;
                  a_cnt_r <= 4'd0;
                  b_cnt_r <= 4'd0;
                  op_r    <= OP_ADD;
               end
            end
            default: begin
               state_r <= ST_ENTER_A;
               busy    <= 1'b0;
               bus_we  <= 1'b0;
               cpu_en  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_io_ctrl.sv
// Self-checking bench for calc_io_ctrl; the bench plays keypad and CPU and predicts bus writes and LCD rows.
module tb_calc_io_ctrl;
   import calc_pkg::*;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         key_valid = 1'b0;
   logic [3:0]   key_code = 4'd0;
   logic         cpu_done = 1'b0;
   logic [31:0]  res_data = 32'd0;
   logic [31:0]  bus_addr, bus_wdata;
   logic         bus_we, cpu_en, busy;
   logic [127:0] row1, row2;

   calc_io_ctrl #(.DIGITS(4), .RES_DIGITS(8), .TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .nrst(nrst), .key_valid(key_valid), .key_code(key_code),
      .cpu_done(cpu_done), .res_data(res_data), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_we(bus_we), .cpu_en(cpu_en), .busy(busy),
      .row1(row1), .row2(row2)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [63:0] wr_q[$];
   int          cpu_en_cnt = 0;
   localparam logic [127:0] BLANK = {16{8'h20}};

   always @(negedge clk) begin
      if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
      if (cpu_en) cpu_en_cnt++;
   end

   function automatic logic [127:0] str2row(input string s);
      logic [127:0] v;
      v = BLANK;
      for (int i = 0; i < s.len() && i < 16; i++) v[127-8*i -: 8] = s[i];
      return v;
   endfunction

   function automatic string op_str(input logic [3:0] op);
      case (op)
         OP_ADD:  return "+";
         OP_SUB:  return "-";
         OP_MUL:  return "x";
         default: return "/";
      endcase
   endfunction

   function automatic logic [127:0] exp_row1(input int a, input logic [3:0] op, input int b);
      return str2row($sformatf("%04d%s%04d", a, op_str(op), b));
   endfunction

   function automatic logic [127:0] exp_row2(input logic signed [31:0] r);
      longint m;
      string  sgn;
      m   = longint'(r);
      sgn = (m < 0) ? "-" : " ";
      if (m < 0) m = -m;
      if (m >= 64'd100000000) return str2row("=OVF");
      return str2row($sformatf("=%s%08d", sgn, m));
   endfunction

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic enter_val(input int v);
      string s;
      s = $sformatf("%0d", v);
      for (int i = 0; i < s.len(); i++) press(4'(s[i] - 8'd48));
   endtask

   // After '#' in ENTER_B: act as CPU, check writes and rows, then clear with '#'
   task automatic finish_calc(input int a, input int b, input logic [3:0] op,
                              input logic signed [31:0] r, input int dly, input string tag);
      bit          bad;
      int          k;
      logic [63:0] ew[3];
      if (op == OP_DIV && b == 0) begin
         repeat (8) @(negedge clk);
         n_tests++;
         if (wr_q.size() != 0 || cpu_en_cnt != 0) begin
            n_fail++;
            $display("FAIL %s div0_quiet: writes=%0d cpu_en_cycles=%0d, expected 0 and 0", tag, wr_q.size(), cpu_en_cnt);
         end
         n_tests++;
         if (row2 !== str2row("=DIV0")) begin
            n_fail++;
            $display("FAIL %s row2: got '%s' expected '=DIV0'", tag, row2);
         end
      end else begin
         k = 0;
         while (!cpu_en && k < 20) begin @(negedge clk); k++; end
         n_tests++;
         if (cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cpu_en_start: got %b expected 1", tag, cpu_en);
         end
         repeat (dly) @(negedge clk);
         cpu_done = 1'b1;
         res_data = r;
         k = 0;
         while (cpu_en && k < 20) begin @(negedge clk); k++; end
         cpu_done = 1'b0;
         res_data = $urandom();
         n_tests++;
         if (cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cpu_en_stop: got %b expected 0", tag, cpu_en);
         end
         k = 0;
         while (row2 === BLANK && k < 80) begin @(negedge clk); k++; end
         ew[0] = {32'd220, 32'(a)};
         ew[1] = {32'd240, 32'(b)};
         ew[2] = {32'd260, 28'd0, op};
         bad = (wr_q.size() != 3);
         if (!bad) for (int i = 0; i < 3; i++) bad |= (wr_q[i] !== ew[i]);
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL %s bus_writes: got %0d writes %p expected %p", tag, wr_q.size(), wr_q, ew);
         end
         n_tests++;
         if (row2 !== exp_row2(r)) begin
            n_fail++;
            $display("FAIL %s row2: got '%s' expected '%s'", tag, row2, exp_row2(r));
         end
      end
      n_tests++;
      if (row1 !== exp_row1(a, op, b) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s row1_busy: got '%s' busy=%b expected '%s' busy=1", tag, row1, busy, exp_row1(a, op, b));
      end
      press(KEY_ENTER);
      n_tests++;
      if (row1 !== BLANK || row2 !== BLANK || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s clear: got '%s' '%s' busy=%b expected blank rows busy=0", tag, row1, row2, busy);
      end
   endtask

   task automatic calc(input int a, input int b, input logic [3:0] op,
                       input logic signed [31:0] r, input int dly, input string tag);
      wr_q.delete();
      cpu_en_cnt = 0;
      enter_val(a);
      press(op);
      enter_val(b);
      press(KEY_ENTER);
      finish_calc(a, b, op, r, dly, tag);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus_addr !== 32'd320 || bus_wdata !== 32'd0 || bus_we !== 1'b0 || cpu_en !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: addr=%0d wdata=%0d we=%b cpu_en=%b busy=%b expected 320 0 0 0 0", bus_addr, bus_wdata, bus_we, cpu_en, busy);
      end
      n_tests++;
      if (row1 !== BLANK || row2 !== BLANK) begin
         n_fail++;
         $display("FAIL reset_rows: got '%s' '%s' expected blank", row1, row2);
      end
   endtask

   task automatic test_basic();
      press(4'd1);
      n_tests++;
      if (row1 !== exp_row1(1, OP_ADD, 0)) begin
         n_fail++;
         $display("FAIL first_digit_row1: got '%s' expected '%s'", row1, exp_row1(1, OP_ADD, 0));
      end
      wr_q.delete();
      cpu_en_cnt = 0;
      press(4'd2); press(OP_ADD); press(4'd3); press(4'd4); press(KEY_ENTER);
      finish_calc(12, 34, OP_ADD, 32'sd46, 5, "basic_add");
   endtask

   task automatic test_negative();
      calc(9, 12, OP_SUB, -32'sd3, 2, "negative");
      press(KEY_RECALL);
      n_tests++;
      if (row1 !== BLANK) begin
         n_fail++;
         $display("FAIL recall_negative_ignored: got '%s' expected blank", row1);
      end
   endtask

   task automatic test_digit_limit_recall();
      calc(3, 4, OP_ADD, 32'sd7, 1, "ans7");
      for (int d = 1; d <= 5; d++) press(4'(d));
      n_tests++;
      if (row1 !== exp_row1(1234, OP_ADD, 0)) begin
         n_fail++;
         $display("FAIL digit_limit: got '%s' expected '%s'", row1, exp_row1(1234, OP_ADD, 0));
      end
      press(KEY_RECALL);
      press(4'd9);
      n_tests++;
      if (row1 !== exp_row1(7, OP_ADD, 0)) begin
         n_fail++;
         $display("FAIL recall_full: got '%s' expected '%s'", row1, exp_row1(7, OP_ADD, 0));
      end
      press(OP_ADD);
      press(4'd1);
      wr_q.delete();
      cpu_en_cnt = 0;
      press(KEY_ENTER);
      finish_calc(7, 1, OP_ADD, 32'sd8, 2, "recall_run");
   endtask

   task automatic test_div0();
      calc(5, 0, OP_DIV, 32'sd0, 0, "div0");
      press(KEY_RECALL);
      n_tests++;
      if (row1 !== exp_row1(8, OP_ADD, 0)) begin
         n_fail++;
         $display("FAIL div0_keeps_ans: got '%s' expected '%s'", row1, exp_row1(8, OP_ADD, 0));
      end
      press(OP_ADD);
      press(4'd2);
      wr_q.delete();
      cpu_en_cnt = 0;
      press(KEY_ENTER);
      finish_calc(8, 2, OP_ADD, 32'sd10, 1, "after_div0");
   endtask

   task automatic test_boundaries();
      calc(1, 1, OP_ADD, 32'sh7FFFFFFF, 0, "ovf_max");
      calc(2, 1, OP_SUB, 32'sh80000000, 3, "ovf_min");
      calc(99, 11, OP_MUL, 32'sd99999999, 1, "max_fit");
      calc(0, 7, OP_SUB, -32'sd99999999, 1, "min_fit");
      calc(5, 5, OP_SUB, 32'sd0, 0, "zero");
   endtask

   task automatic test_random();
      int a, b, rr;
      logic [3:0] op;
      for (int it = 0; it < 8; it++) begin
         a  = $urandom_range(9999, 0);
         b  = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(9999, 0);
         op = 4'(OP_ADD + $urandom_range(3, 0));
         case (op)
            OP_ADD:  rr = a + b;
            OP_SUB:  rr = a - b;
            OP_MUL:  rr = a * b;
            default: rr = (b == 0) ? 0 : a / b;
         endcase
         calc(a, b, op, 32'(rr), $urandom_range(6, 0), $sformatf("random%0d", it));
      end
   endtask

   task automatic test_reset_mid_run();
      int k;
      press(4'd1); press(OP_ADD); press(4'd1); press(KEY_ENTER);
      k = 0;
      while (!cpu_en && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      nrst = 1'b0;
      #1;
      n_tests++;
      if (bus_addr !== 32'd320 || bus_wdata !== 32'd0 || bus_we !== 1'b0 || cpu_en !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset_outputs: addr=%0d wdata=%0d we=%b cpu_en=%b busy=%b expected 320 0 0 0 0", bus_addr, bus_wdata, bus_we, cpu_en, busy);
      end
      n_tests++;
      if (row1 !== BLANK || row2 !== BLANK) begin
         n_fail++;
         $display("FAIL midrun_reset_rows: got '%s' '%s' expected blank", row1, row2);
      end
      @(negedge clk);
      nrst = 1'b1;
      press(KEY_RECALL);
      press(4'd5);
      n_tests++;
      if (row1 !== exp_row1(5, OP_ADD, 0)) begin
         n_fail++;
         $display("FAIL post_reset_entry: got '%s' expected '%s'", row1, exp_row1(5, OP_ADD, 0));
      end
      press(OP_ADD);
      press(4'd5);
      wr_q.delete();
      cpu_en_cnt = 0;
      press(KEY_ENTER);
      finish_calc(5, 5, OP_ADD, 32'sd10, 1, "post_reset_run");
   endtask

`ifdef CALC_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      cpu_en_cnt = 0;
      press(4'd2); press(OP_MUL); press(4'd3); press(KEY_ENTER);
      k = 0;
      while (!cpu_en && k < 20) begin @(negedge clk); k++; end
      k = 0;
      while (cpu_en && k < 200) begin @(negedge clk); k++; end
      n_tests++;
      if (cpu_en_cnt != 50) begin
         n_fail++;
         $display("FAIL timeout_cycles: cpu_en high for %0d cycles expected 50", cpu_en_cnt);
      end
      n_tests++;
      if (row2 !== str2row("=TIME") || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_row2: got '%s' busy=%b expected '=TIME' busy=1", row2, busy);
      end
      press(KEY_ENTER);
      n_tests++;
      if (row1 !== BLANK || row2 !== BLANK || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_clear: got '%s' '%s' busy=%b expected blank rows busy=0", row1, row2, busy);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_digit_limit_recall();
      test_div0();
      test_boundaries();
      test_random();
      test_reset_mid_run();
`ifdef CALC_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
